// File: rtl/msu_data_fetch_if.sv
// Bundle for the MSU data-port prefetch stage: register-block side and word-fetch memory side.
// master = register block plus memory responder, slave = msu_data_fetch.
interface msu_data_fetch_if;
   logic [31:0] msu_data_addr;
   logic        msu_data_seek;
   logic        msu_data_req;
   logic [7:0]  msu_data_out;
   logic        msu_data_busy;
   logic        mem_req;
   logic [30:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_din;

   modport master (
      output msu_data_addr, msu_data_seek, msu_data_req, mem_ack, mem_din,
      input  msu_data_out, msu_data_busy, mem_req, mem_addr
   );

   modport slave (
      input  msu_data_addr, msu_data_seek, msu_data_req, mem_ack, mem_din,
      output msu_data_out, msu_data_busy, mem_req, mem_addr
   );
endinterface

// File: rtl/msu_data_fetch.sv
// MSU data prefetch: fetches 16-bit words after a seek, buffers bytes, presents the head byte.
// Optional macro MSU_DATA_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
//
// state    | meaning
// ST_IDLE  | no stream, acks ignored
// ST_FILL  | fetching words into the byte FIFO
// ST_DRAIN | seek arrived mid-request, waiting out the stale ack
module msu_data_fetch #(
   parameter int DEPTH   = 16,
   parameter int PREFILL = 4
) (
   input  logic CLK,
   input  logic RST,
`ifdef MSU_DATA_UNDERFLOW_CNT_EN
   output logic [15:0] underflow_cnt,
`endif
   msu_data_fetch_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]    state;
   logic [7:0]    fifo_mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
   logic [CW-1:0] count, count_nxt, remain;
   logic [31:0]   fetch_addr;
   logic          skip_low;
   logic [7:0]    data_out;
   logic          busy;
   logic          req;
   logic [30:0]   req_addr;

   logic          ack_v, push_en, pop_en, issue;
   logic [1:0]    push_n;
   logic [7:0]    first_byte;

   assign bus.msu_data_out  = data_out;
   assign bus.msu_data_busy = busy;
   assign bus.mem_req       = req;
   assign bus.mem_addr      = req_addr;

   always_comb begin
      // an ack only counts against an outstanding request; this also covers IDLE after reset
      ack_v      = bus.mem_ack && req;
      push_en    = ack_v && (state == ST_FILL) && !bus.msu_data_seek;
      push_n     = !push_en ? 2'd0 : (skip_low ? 2'd1 : 2'd2);
      pop_en     = bus.msu_data_req && !bus.msu_data_seek && (count != '0);
      remain     = count - CW'(pop_en);
      count_nxt  = remain + CW'(push_n);
      rd_ptr_nxt = rd_ptr + AW'(pop_en);
      first_byte = skip_low ? bus.mem_din[15:8] : bus.mem_din[7:0];
      issue      = (state == ST_FILL) && !bus.msu_data_seek && !req
                   && (count <= CW'(DEPTH - 2));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_IDLE;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         fetch_addr <= '0;
         skip_low   <= 1'b0;
         data_out   <= 8'h00;
         busy       <= 1'b0;
         req        <= 1'b0;
         req_addr   <= '0;
      end else if (bus.msu_data_seek) begin
         // a request acked in the seek cycle is complete; only a still-open one needs draining
         state      <= (req && !ack_v) ? ST_DRAIN : ST_FILL;
         if (ack_v)
            req <= 1'b0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         fetch_addr <= {bus.msu_data_addr[31:1], 1'b0};
         skip_low   <= bus.msu_data_addr[0];
         busy       <= 1'b1;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         wr_ptr <= wr_ptr + AW'(push_n);
         count  <= count_nxt;
         if (ack_v) begin
            req <= 1'b0;
         end else if (issue) begin
            req      <= 1'b1;
            req_addr <= fetch_addr[31:1];
         end
         if (push_en) begin
            fetch_addr <= fetch_addr + 32'd2;
            skip_low   <= 1'b0;
         end
         if (ack_v && (state == ST_DRAIN))
            state <= ST_FILL;
         if (count_nxt >= CW'(PREFILL))
            busy <= 1'b0;
         // head is either an already stored byte or, when the FIFO runs dry, the first byte pushed now
         if (remain != '0)
            data_out <= fifo_mem[rd_ptr_nxt];
         else if (push_en)
            data_out <= first_byte;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_en) begin
         if (skip_low) begin
            fifo_mem[wr_ptr] <= bus.mem_din[15:8];
         end else begin
            fifo_mem[wr_ptr]         <= bus.mem_din[7:0];
            fifo_mem[wr_ptr + AW'(1)] <= bus.mem_din[15:8];
         end
      end
   end

`ifdef MSU_DATA_UNDERFLOW_CNT_EN
   always_ff @(posedge CLK) begin
      if (RST || bus.msu_data_seek)
         underflow_cnt <= 16'h0000;
      else if (bus.msu_data_req && (count == '0) && (underflow_cnt != 16'hFFFF))
         underflow_cnt <= underflow_cnt + 16'd1;
   end
`endif

endmodule
